xbee_tx_arbiter: RTL and testbench

- Shares the single XBee transmit path among up to eight on-chip requesters, such as telemetry, status and debug sources.
- Grants are round-robin. Each granted byte goes out as a 4-byte frame: SOF, source ID, payload, XOR checksum.
- The block drives the `xbee` wrapper's `DataIn`/`send_data` pair. It paces bytes by a fixed per-character period, because the wrapper exposes no transmitter-busy status.
- It sits between the application logic and the `xbee` instance.

---
 rtl/xbee_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_xbee_tx_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbee_tx_arbiter.sv
// Round-robin arbiter that frames one byte per grant as SOF/ID/payload/XOR
// and paces the xbee DataIn/send_data pair by a fixed per-character period.
module xbee_tx_arbiter #(
  parameter int          BAUD         = 9600,
  parameter int          CLKFREQ      = 100_000_000,
  parameter int          NUM_REQ      = 4,
  parameter logic [7:0]  SOF          = 8'hA5,
  parameter int          PULSE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             DataIn,
  output logic                   send_data,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic [1:0]             state_dbg
);

  // Handshake: a source raises req[i] with its payload stable and holds both
  // until ack[i] pulses for one cycle; the payload is captured on that edge.

  localparam int BIT_CYCLES  = CLKFREQ / BAUD;
  localparam int BYTE_CYCLES = 11 * BIT_CYCLES;
  localparam int GAP_CYCLES  = BYTE_CYCLES - PULSE_CYCLES;
  localparam int CW          = $clog2(BYTE_CYCLES + 1);

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         last_grant_q, last_grant_d;
  logic [7:0]         payload_q, payload_d;
  logic [7:0]         chk_q, chk_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [7:0]         data_q, data_d;
  logic               send_q, send_d;
  logic [2:0]         grant_q, grant_d;
  logic               busy_q, busy_d;

  // Padded to the full 8-source width so the 3-bit grant index is exact.
  logic [7:0]         req_pad;
  logic [63:0]        data_pad;
  logic               found;
  logic [2:0]         pick;
  logic [7:0]         pick_byte;

  assign req_pad   = 8'(req);
  assign data_pad  = 64'(req_data);
  assign pick_byte = data_pad[{pick, 3'b000} +: 8];

  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_pad[3'((int'(last_grant_q) + k) % NUM_REQ)]) begin
        found = 1'b1;
        pick  = 3'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    payload_d    = payload_q;
    chk_d        = chk_q;
    ack_d        = '0;
    data_d       = data_q;
    send_d       = send_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          payload_d    = pick_byte;
          chk_d        = SOF ^ {5'b0, pick} ^ pick_byte;
          grant_d      = pick;
          last_grant_d = pick;
          ack_d        = NUM_REQ'(1) << pick;
          data_d       = SOF;
          send_d       = 1'b1;
          byte_idx_d   = 2'd0;
          cnt_d        = '0;
          busy_d       = 1'b1;
          state_d      = S_PULSE;
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          send_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0:    data_d = {5'b0, grant_q};
              2'd1:    data_d = payload_q;
              default: data_d = chk_q;
            endcase
            send_d  = 1'b1;
            state_d = S_PULSE;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // last_grant resets to the top source so the first grant lands on source 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= 2'd0;
      cnt_q        <= '0;
      last_grant_q <= 3'(NUM_REQ - 1);
      payload_q    <= 8'd0;
      chk_q        <= 8'd0;
      ack_q        <= '0;
      data_q       <= 8'd0;
      send_q       <= 1'b0;
      grant_q      <= 3'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      payload_q    <= payload_d;
      chk_q        <= chk_d;
      ack_q        <= ack_d;
      data_q       <= data_d;
      send_q       <= send_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign DataIn    = data_q;
  assign send_data = send_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_xbee_tx_arbiter.sv
// Bench for xbee_tx_arbiter: table vectors, hand-written corner sequences and
// random frames checked against a frame-level round-robin model.
module tb_xbee_tx_arbiter;

  localparam int         NREQ  = 4;
  localparam int         BYTEC = 110;
  localparam int         PULSE = 4;
  localparam logic [7:0] SOFB  = 8'hA5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [31:0]     req_data = '0;
  logic [NREQ-1:0] ack;
  logic [7:0]      DataIn;
  logic            send_data;
  logic [2:0]      grant_id;
  logic            busy;
  logic [1:0]      state_dbg;

  xbee_tx_arbiter #(
    .BAUD(100), .CLKFREQ(1000), .NUM_REQ(NREQ), .SOF(SOFB), .PULSE_CYCLES(PULSE)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .DataIn(DataIn), .send_data(send_data), .grant_id(grant_id), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor / scoreboard ----------------
  logic [7:0]  byte_q[$];
  int          rise_q[$];
  int          hi_q[$];
  logic [3:0]  ack_q[$];
  int          ack_cyc_q[$];
  int          busy_len_q[$];
  logic [31:0] exp_q[$];
  int          sd_rise, busy_rise, busy_fall_cyc;
  logic        sd_prev = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      sd_prev   = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (send_data && !sd_prev) begin
        byte_q.push_back(DataIn);
        rise_q.push_back(cyc);
        sd_rise = cyc;
      end
      if (!send_data && sd_prev) hi_q.push_back(cyc - sd_rise);
      if (ack != 0) begin
        ack_q.push_back(ack);
        ack_cyc_q.push_back(cyc);
      end
      if (busy && !busy_prev) busy_rise = cyc;
      if (!busy && busy_prev) begin
        busy_len_q.push_back(cyc - busy_rise);
        busy_fall_cyc = cyc;
      end
      sd_prev   = send_data;
      busy_prev = busy;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int model_last = NREQ - 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Winner is the requester with the smallest forward distance from last grant.
  function automatic int model_pick(input int last, input logic [3:0] mask);
    int best, best_d, d;
    best = -1;
    best_d = NREQ + 1;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - last - 1 + 2 * NREQ) % NREQ;
      if (mask[i] && d < best_d) begin
        best = i;
        best_d = d;
      end
    end
    return best;
  endfunction

  function automatic logic [31:0] model_frame(input int g, input logic [7:0] p);
    logic [7:0] id;
    id = 8'(g);
    return {SOFB, id, p, SOFB ^ id ^ p};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_sb();
    byte_q.delete(); rise_q.delete(); hi_q.delete(); ack_q.delete();
    ack_cyc_q.delete(); busy_len_q.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    req = '0;
    tick();
    tick();
    reset = 1'b1;
    clear_sb();
    model_last = NREQ - 1;
  endtask

  task automatic wait_ack(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      tick();
      if (ack != 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("busy_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input int base, input logic [31:0] exp);
    logic [31:0] e;
    e = exp;
    for (int i = 0; i < 4; i++) begin
      if (base + i < byte_q.size())
        chk($sformatf("byte%0d", i), 32'(byte_q[base + i]), 32'(e[31 - 8*i -: 8]));
      else
        chk($sformatf("byte%0d_missing", i), 32'd0, 32'd1);
    end
  endtask

  // One complete frame: request, ack, drop request, wait out the frame, check.
  task automatic run_frame(input logic [3:0] mask, input logic [31:0] data,
                           input int exp_g, input logic [31:0] exp_bytes);
    bit ok;
    clear_sb();
    exp_q.push_back(exp_bytes);
    req = mask;
    req_data = data;
    wait_ack(1000, ok);
    if (ok) begin
      chk("ack_onehot", 32'(ack), 32'(4'b1 << exp_g));
      chk("grant_id", 32'(grant_id), 32'(exp_g));
      chk("start_byte_sof", 32'(DataIn), 32'(SOFB));
    end
    req = '0;
    tick();
    chk("ack_one_cycle", 32'(ack), 32'd0);
    wait_idle(600);
    chk("byte_count", byte_q.size(), 4);
    check_frame(0, exp_q.pop_front());
    if (rise_q.size() > 0 && ack_cyc_q.size() > 0)
      chk("first_rise_latency", rise_q[0] - ack_cyc_q[0], 0);
    for (int i = 1; i < rise_q.size(); i++) chk("byte_period", rise_q[i] - rise_q[i-1], BYTEC);
    for (int i = 0; i < hi_q.size(); i++) chk("pulse_width", hi_q[i], PULSE);
    chk("busy_len", (busy_len_q.size() > 0) ? busy_len_q[0] : -1, 4 * BYTEC);
    model_last = exp_g;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          g;
    logic [31:0] bytes;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;
    logic [3:0]  m;
    logic [31:0] d;
    int          g;

    vecs[0] = '{4'b0100, 32'h003C_0000, 2, 32'hA502_3C9B};
    vecs[1] = '{4'b1001, 32'h1100_0077, 3, 32'hA503_11B7};
    vecs[2] = '{4'b1001, 32'h1100_00A5, 0, 32'hA500_A500};
    vecs[3] = '{4'b0110, 32'h0000_FF00, 1, 32'hA501_FF5B};
    vecs[4] = '{4'b0001, 32'h0000_0000, 0, 32'hA500_00A5};

    // reset state
    #3;
    chk("rst_send_data", 32'(send_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_datain", 32'(DataIn), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    do_reset();

    for (int i = 0; i < 5; i++) run_frame(vecs[i].req, vecs[i].data, vecs[i].g, vecs[i].bytes);

    // round-robin with a continuously held request
    do_reset();
    req_data = 32'h4433_2211;
    req = 4'hF;
    for (int n = 0; n < 5 * 441 + 50; n++) begin
      tick();
      if (ack_q.size() >= 5) break;
    end
    req = '0;
    wait_idle(600);
    chk("rr_ack_count", ack_q.size(), 5);
    for (int k = 0; k < 5 && k < ack_q.size(); k++) begin
      chk($sformatf("rr_ack%0d", k), 32'(ack_q[k]), 32'(4'b1 << (k % 4)));
      if (4*k + 1 < byte_q.size()) chk($sformatf("rr_id%0d", k), 32'(byte_q[4*k+1]), k % 4);
      if (k > 0 && 4*k < rise_q.size()) chk("rr_frame_period", rise_q[4*k] - rise_q[4*k-4], 4*BYTEC + 1);
    end
    model_last = 0;

    // late request raised during byte 2 of source 0's frame
    do_reset();
    req = 4'b0001;
    req_data = 32'h0000_5A00;
    wait_ack(1000, ok);
    req = '0;
    for (int n = 0; n < 400 && rise_q.size() < 3; n++) tick();
    req = 4'b0010;
    for (int n = 0; n < 600; n++) begin
      tick();
      if (ack != 0) break;
    end
    chk("late_ack_value", 32'(ack), 32'b0010);
    chk("late_ack_count", ack_q.size(), 2);
    if (ack_cyc_q.size() >= 2) chk("late_ack_after_idle", ack_cyc_q[1] - busy_fall_cyc, 1);
    req = '0;
    tick();
    wait_idle(600);
    chk("late_byte_count", byte_q.size(), 8);
    check_frame(0, model_frame(0, 8'h00));
    check_frame(4, model_frame(1, 8'h5A));
    model_last = 1;

    // reset during the pulse of byte 1
    tick();
    req = 4'b0100;
    req_data = 32'h0077_0000;
    wait_ack(1000, ok);
    req = '0;
    for (int n = 0; n < 300 && rise_q.size() < 2; n++) tick();
    tick();
    chk("pre_rst_send_data", 32'(send_data), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_send_data", 32'(send_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_datain", 32'(DataIn), 32'd0);
    chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
    chk("mid_rst_state", 32'(state_dbg), 32'd0);
    tick();
    reset = 1'b1;
    clear_sb();
    model_last = NREQ - 1;
    run_frame(4'b1000, 32'hC300_0000, 3, model_frame(3, 8'hC3));

    // random frames against the model
    for (int t = 0; t < 14; t++) begin
      m = 4'($urandom_range(1, 15));
      d = $urandom;
      g = model_pick(model_last, m);
      run_frame(m, d, g, model_frame(g, d[8*g +: 8]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
